// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, timing defaults and parity helper.
// Also imported by the PS/2 receiver.
package ps2_pkg;

    localparam int unsigned INHIBIT_CYCLES_DEFAULT = 2700;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 405000;
    localparam int unsigned TIMER_WIDTH            = 19;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        BITS,
        ACK,
        WAIT_IDLE
    } txState_t;

    // Odd parity: the frame's data bits plus this bit always contain an odd number of ones.
    function automatic logic oddParity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte request/response channel between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;

    logic       txValid;
    logic [7:0] txData;
    logic       txReady;
    logic       txDone;
    logic       txAckErr;
    logic       txTimeout;

    modport master (
        output txValid, txData,
        input  txReady, txDone, txAckErr, txTimeout
    );

    modport slave (
        input  txValid, txData,
        output txReady, txDone, txAckErr, txTimeout
    );

endinterface

// File: rtl/ps2_tx_timer.sv
// Loadable down-counter shared by the inhibit delay and the device-clock watchdog.
module ps2_tx_timer
    import ps2_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [TIMER_WIDTH-1:0] loadValue,
    input  logic                   enable,
    output logic                   zero
);

    logic [TIMER_WIDTH-1:0] count;

    // Stops at zero so an expired interval stays expired until reloaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (enable && !zero) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (open-drain clock/data enables).
// Optional watchdog on device clocking enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         ps2Clk,
    input  logic         ps2Data,
    ps2_host_tx_if.slave tx,
    output logic         clkOe,
    output logic         dataOe,
    output logic         rxInhibit
);

    localparam logic [TIMER_WIDTH-1:0] INHIBIT_LOAD = TIMER_WIDTH'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LOAD = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    txState_t state;
    txState_t stateNext;

    logic [7:0]             txByte;
    logic                   parityBit;
    logic                   dataOeReg;
    logic                   dataOeNext;
    logic [3:0]             bitCnt;
    logic [3:0]             bitCntNext;
    logic                   ackErr;
    logic                   ackErrNext;
    logic                   prevClk;
    logic                   fallEdge;
    logic                   accept;
    logic                   startBit;
    logic                   doneNow;
    logic                   timeoutNow;
    logic                   watchdogFire;
    logic                   timerLoad;
    logic [TIMER_WIDTH-1:0] timerLoadValue;
    logic                   timerEnable;
    logic                   timerZero;

    assign fallEdge    = prevClk && !ps2Clk;
    assign timerEnable = (state != IDLE);

    ps2_tx_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (timerLoad),
        .loadValue (timerLoadValue),
        .enable    (timerEnable),
        .zero      (timerZero)
    );

`ifdef PS2_TX_TIMEOUT_EN
    assign watchdogFire = ((state == BITS) || (state == ACK) || (state == WAIT_IDLE)) && timerZero;
`else
    assign watchdogFire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext      = state;
        dataOeNext     = dataOeReg;
        bitCntNext     = bitCnt;
        ackErrNext     = ackErr;
        timerLoad      = 1'b0;
        timerLoadValue = TIMEOUT_LOAD;
        accept         = 1'b0;
        startBit       = 1'b0;
        doneNow        = 1'b0;
        timeoutNow     = 1'b0;

        case (state)
            IDLE: begin
                dataOeNext = 1'b0;
                ackErrNext = 1'b0;
                if (tx.txValid) begin
                    accept         = 1'b1;
                    timerLoad      = 1'b1;
                    timerLoadValue = INHIBIT_LOAD;
                    stateNext      = INHIBIT;
                end
            end
            INHIBIT: begin
                if (timerZero) begin
                    startBit   = 1'b1;
                    dataOeNext = 1'b1;
                    bitCntNext = '0;
                    timerLoad  = 1'b1;
                    stateNext  = BITS;
                end
            end
            BITS: begin
                // bitCnt holds the number of edges already seen; edge n = bitCnt + 1.
                if (fallEdge) begin
                    timerLoad  = 1'b1;
                    bitCntNext = bitCnt + 4'd1;
                    if (bitCnt < 4'd8) begin
                        dataOeNext = ~txByte[bitCnt[2:0]];
                    end else if (bitCnt == 4'd8) begin
                        dataOeNext = ~parityBit;
                    end else begin
                        dataOeNext = 1'b0;
                        stateNext  = ACK;
                    end
                end
            end
            ACK: begin
                if (fallEdge) begin
                    timerLoad  = 1'b1;
                    ackErrNext = ps2Data;
                    stateNext  = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (ps2Clk && ps2Data) begin
                    doneNow   = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        if (watchdogFire) begin
            timeoutNow = 1'b1;
            doneNow    = 1'b1;
            dataOeNext = 1'b0;
            ackErrNext = 1'b0;
            timerLoad  = 1'b0;
            stateNext  = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txByte    <= '0;
            parityBit <= 1'b0;
            dataOeReg <= 1'b0;
            bitCnt    <= '0;
            ackErr    <= 1'b0;
            prevClk   <= 1'b1;
        end else begin
            prevClk   <= ps2Clk;
            dataOeReg <= dataOeNext;
            bitCnt    <= bitCntNext;
            ackErr    <= ackErrNext;
            if (accept) begin
                txByte    <= tx.txData;
                parityBit <= oddParity(tx.txData);
            end
        end
    end

    // Start bit is driven combinationally so it overlaps the last inhibit cycle.
    assign clkOe        = (state == INHIBIT);
    assign dataOe       = (dataOeReg && !timeoutNow) || startBit;
    assign rxInhibit    = (state != IDLE);
    assign tx.txReady   = (state == IDLE);
    assign tx.txDone    = doneNow;
    assign tx.txAckErr  = doneNow && !timeoutNow && ackErr;
    assign tx.txTimeout = timeoutNow;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on wired-AND lines.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned TB_INHIBIT = 2700;
    localparam int unsigned TB_TIMEOUT = 4000;
    localparam int unsigned HALF       = 20;

    logic clk        = 1'b0;
    logic reset      = 1'b1;
    logic ps2ClkDrv  = 1'b1;
    logic ps2DataDrv = 1'b1;
    logic ps2Clk;
    logic ps2Data;
    logic clkOe;
    logic dataOe;
    logic rxInhibit;

    ps2_host_tx_if tx ();

    assign ps2Clk  = ps2ClkDrv && !clkOe;
    assign ps2Data = ps2DataDrv && !dataOe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (TB_INHIBIT),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2Clk    (ps2Clk),
        .ps2Data   (ps2Data),
        .tx        (tx),
        .clkOe     (clkOe),
        .dataOe    (dataOe),
        .rxInhibit (rxInhibit)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned acceptCount = 0;
    int unsigned acceptCyc   = 0;
    int unsigned doneCount   = 0;
    int unsigned doneCyc     = 0;
    int unsigned clkOeCnt    = 0;
    int unsigned strayFlags  = 0;
    logic lastAckErr     = 1'b0;
    logic lastTimeout    = 1'b0;
    logic oeAtDone       = 1'b0;
    logic prevDone       = 1'b0;
    logic readyAfterDone = 1'b0;

    // Mid-cycle observer of the response side.
    always @(negedge clk) begin
        prevDone <= tx.txDone;
        if (prevDone) readyAfterDone <= tx.txReady;
        if (tx.txValid && tx.txReady) begin
            acceptCount    <= acceptCount + 1;
            acceptCyc      <= cyc;
            clkOeCnt       <= 0;
            readyAfterDone <= 1'b0;
        end else if (clkOe) begin
            clkOeCnt <= clkOeCnt + 1;
        end
        if (tx.txDone) begin
            doneCount   <= doneCount + 1;
            doneCyc     <= cyc;
            lastAckErr  <= tx.txAckErr;
            lastTimeout <= tx.txTimeout;
            oeAtDone    <= clkOe || dataOe;
        end else if (tx.txAckErr || tx.txTimeout) begin
            strayFlags <= strayFlags + 1;
        end
    end

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        int unsigned a = acceptCount;
        bit ok = 1'b0;
        tx.txValid = 1'b1;
        tx.txData  = b;
        for (int i = 0; i < 8; i++) begin
            step();
            if (acceptCount != a) begin
                ok = 1'b1;
                break;
            end
        end
        tx.txValid = 1'b0;
        checkVal("accept", 32'(ok), 1);
    endtask

    // Device side: wait for the start bit, then clock nEdges falling edges.
    task automatic deviceRun(input int unsigned nEdges, input logic doAck,
                             output logic [10:0] frame, output bit started);
        frame   = '0;
        started = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (!clkOe && !ps2Data && rxInhibit) begin
                started = 1'b1;
                break;
            end
            step();
        end
        if (!started) return;
        frame[0] = ps2Data;
        repeat (HALF) step();
        for (int e = 1; e <= int'(nEdges); e++) begin
            if (e == 11 && doAck) ps2DataDrv = 1'b0;
            ps2ClkDrv = 1'b0;
            repeat (HALF) step();
            ps2ClkDrv = 1'b1;
            if (e <= 10) frame[e] = ps2Data;
            repeat (HALF) step();
        end
        ps2DataDrv = 1'b1;
        repeat (4) step();
    endtask

    task automatic runNormal(input string tag, input logic [7:0] b, input logic expPar,
                             input logic doAck);
        logic [10:0] f;
        bit st;
        int unsigned d = doneCount;
        sendByte(b);
        deviceRun(11, doAck, f, st);
        checkVal({tag, ".started"}, 32'(st), 1);
        checkVal({tag, ".startStop"}, {30'd0, f[10], f[0]}, 2'b10);
        checkVal({tag, ".data"}, 32'(f[8:1]), 32'(b));
        checkVal({tag, ".parity"}, 32'(f[9]), 32'(expPar));
        checkVal({tag, ".inhibitLen"}, clkOeCnt, TB_INHIBIT);
        checkVal({tag, ".done"}, doneCount, d + 1);
        checkVal({tag, ".flags"}, {30'd0, lastTimeout, lastAckErr}, {31'd0, !doAck});
        checkVal({tag, ".readyAfter"}, 32'(readyAfterDone), 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL globalTimeout got=%0d cycles exp=finish", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [10:0] f;
        bit st;
        int unsigned a;
        int unsigned d;
        bit ok;

        tx.txValid = 1'b0;
        tx.txData  = 8'h00;
        repeat (3) step();
        checkVal("rst.outputs", {27'd0, clkOe, dataOe, rxInhibit, tx.txDone, tx.txTimeout}, 0);
        checkVal("rst.ready", 32'(tx.txReady), 1);
        reset = 1'b0;
        step();
        checkVal("idle.ready", 32'(tx.txReady), 1);

        runNormal("ed", 8'hED, 1'b1, 1'b1);
        runNormal("x01", 8'h01, 1'b0, 1'b1);
        runNormal("xff", 8'hFF, 1'b1, 1'b1);
        runNormal("nack", 8'h55, 1'b1, 1'b0);

        // Reset mid-transfer after edge 4; byte 0x00 leaves dataOe pulling low.
        d = doneCount;
        sendByte(8'h00);
        deviceRun(4, 1'b1, f, st);
        checkVal("mid.started", 32'(st), 1);
        checkVal("mid.preOe", {30'd0, clkOe, dataOe}, 2'b01);
        reset = 1'b1;
        #1;
        checkVal("mid.asyncOe", {29'd0, clkOe, dataOe, rxInhibit}, 0);
        step();
        step();
        reset = 1'b0;
        step();
        checkVal("mid.ready", 32'(tx.txReady), 1);
        repeat (100) step();
        checkVal("mid.noDone", doneCount, d);

        // txValid held with txData changed after accept.
        a = acceptCount;
        d = doneCount;
        tx.txValid = 1'b1;
        tx.txData  = 8'hA5;
        for (int i = 0; i < 8 && acceptCount == a; i++) step();
        tx.txData = 8'h3C;
        deviceRun(11, 1'b1, f, st);
        checkVal("hold.data1", 32'(f[8:1]), 32'h0000_00A5);
        checkVal("hold.parity1", 32'(f[9]), 1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (acceptCount == a + 2) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        tx.txValid = 1'b0;
        checkVal("hold.secondAccept", 32'(ok), 1);
        checkVal("hold.doneOnce", doneCount, d + 1);
        checkVal("hold.acceptAfterDone", acceptCyc - doneCyc, 1);
        deviceRun(11, 1'b1, f, st);
        checkVal("hold.data2", 32'(f[8:1]), 32'h0000_003C);
        checkVal("hold.done2", doneCount, d + 2);

`ifdef PS2_TX_TIMEOUT_EN
        d = doneCount;
        sendByte(8'h5A);
        for (int i = 0; i < int'(TB_INHIBIT + TB_TIMEOUT + 100); i++) begin
            if (doneCount != d) break;
            step();
        end
        checkVal("to.done", doneCount, d + 1);
        checkVal("to.latency", doneCyc - acceptCyc, TB_INHIBIT + TB_TIMEOUT);
        checkVal("to.flags", {30'd0, lastTimeout, lastAckErr}, 2'b10);
        checkVal("to.oeAtDone", 32'(oeAtDone), 0);
        checkVal("to.oeAfter", {30'd0, clkOe, dataOe}, 0);
        checkVal("to.ready", 32'(tx.txReady), 1);
`endif

        checkVal("strayFlags", strayFlags, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 2700: clk cycles ps2Clk is held low before the start bit.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 405000: maximum clk cycles allowed between device clock falling edges.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port ps2Clk, input, 1: PS/2 clock line level, already synchronized/debounced upstream.
REQ-006 SHALL have port ps2Data, input, 1: PS/2 data line level, already synchronized/debounced upstream.
REQ-007 SHALL have port txValid, input, 1: byte request.
REQ-008 SHALL have port txData, input, 8: byte to send.
REQ-009 SHALL have port txReady, output, 1: block idle and accepting a request.
REQ-010 SHALL have port clkOe, output, 1: 1 = pull the PS/2 clock line low (open-drain); 0 = release.
REQ-011 SHALL have port dataOe, output, 1: 1 = pull the PS/2 data line low; 0 = release.
REQ-012 SHALL have port txDone, output, 1: one-cycle pulse when a transfer ends, for any reason.
REQ-013 SHALL have port txAckErr, output, 1: valid with txDone; 1 = device did not acknowledge.
REQ-014 SHALL have port txTimeout, output, 1: valid with txDone; 1 = transfer aborted by watchdog.
REQ-015 SHALL have port rxInhibit, output, 1: high whenever the state is not IDLE, so the PS/2 receiver ignores the line.

Function
REQ-016 SHALL capture txData and compute the odd-parity bit (parity = ~^txData) in the cycle where txValid && txReady, then enter INHIBIT.
REQ-017 SHALL use states IDLE, INHIBIT, BITS, ACK and WAIT_IDLE, and in IDLE SHALL drive txReady=1 with clkOe=dataOe=0.
REQ-018 SHALL, in INHIBIT, hold clkOe=1 for exactly INHIBIT_CYCLES cycles, assert dataOe=1 (start bit) in the last of those cycles, and then enter BITS with clkOe=0.
REQ-019 SHALL detect a falling edge as prevClk && !ps2Clk, with prevClk registered every cycle, and SHALL ignore falling edges outside BITS and ACK.
REQ-020 SHALL, in BITS on falling edges 1-8, set dataOe to the inverse of txData bit 0-7 (LSB first).
REQ-021 SHALL, in BITS, set dataOe to the inverse of the parity bit on falling edge 9.
REQ-022 SHALL, in BITS on falling edge 10, set dataOe=0 (stop bit) and enter ACK.
REQ-023 SHALL, in ACK, sample ps2Data on the next falling edge (edge 11), set txAckErr to the sampled value (0 = ack), and enter WAIT_IDLE.
REQ-024 SHALL, in WAIT_IDLE, wait until ps2Clk=1 and ps2Data=1 in the same cycle, then pulse txDone and return to IDLE.
REQ-025 SHALL, for a normal transfer, give txReady=1 in the cycle after the txDone pulse.
REQ-026 SHALL ignore txValid while txReady=0, with no queueing.
REQ-027 SHALL hold txAckErr and txTimeout at 0 except in the cycle where txDone is asserted.

Reset
REQ-028 SHALL, on reset asserted, immediately and asynchronously force state=IDLE, clkOe=0, dataOe=0, txDone=0, txAckErr=0, txTimeout=0, rxInhibit=0 and prevClk=1.
REQ-029 SHALL, when reset is asserted mid-transfer, abort the transfer without any txDone pulse, and SHALL drive txReady=1 from the first clock after reset deasserts.

Configuration
REQ-030 SHALL, with macro PS2_TX_TIMEOUT_EN defined, restart a watchdog at entry to BITS and on every falling edge in BITS and ACK.
REQ-031 SHALL, with PS2_TX_TIMEOUT_EN defined, on the watchdog reaching TIMEOUT_CYCLES in BITS, ACK or WAIT_IDLE, release both lines, pulse txDone with txTimeout=1 and txAckErr=0, and enter IDLE in the same transition.
REQ-032 SHALL, with PS2_TX_TIMEOUT_EN undefined, wait indefinitely in BITS, ACK and WAIT_IDLE and tie txTimeout to 0.

Structure
REQ-033 SHALL take the state encodings and the INHIBIT_CYCLES/TIMEOUT_CYCLES defaults from shared package ps2_pkg, which the PS/2 receiver also uses.
REQ-034 SHALL implement the inhibit and watchdog counting in one sub-module, ps2_tx_timer: a 19-bit loadable down-counter with load, enable and zero outputs.

Verification
REQ-035 SHALL cover: send 0xED with device model acking -> data bits 1,0,1,1,0,1,1,1, parity 1, txDone with txAckErr=0 and txTimeout=0.
REQ-036 SHALL cover: send 0x01 and then 0xFF -> parity bits 0 and 1 respectively; clkOe low exactly 2700 cycles each time.
REQ-037 SHALL cover: device leaves data high at edge 11 -> txDone with txAckErr=1.
REQ-038 SHALL cover, with PS2_TX_TIMEOUT_EN defined: device never clocks -> txDone with txTimeout=1 exactly 2700+405000 cycles after accept, and both OEs 0.
REQ-039 SHALL cover: reset pulse after edge 4 -> clkOe=dataOe=0 with no clock edge needed, no txDone, txReady=1 after reset release.
REQ-040 SHALL cover: txValid held high during a transfer with txData changed mid-transfer -> the original byte is sent unchanged, and a second transfer starts only after txReady returns.
